// File: rtl/fifo_pkg.sv
// Shared default geometry for the synchronous FIFO and its storage array.
`timescale 1ns/1ps
package fifo_pkg;
    localparam int DEF_SIZE  = 8;  // data word width in bits
    localparam int DEF_DEPTH = 2;  // address width; capacity is 2**DEPTH entries
endpackage

// File: rtl/fifo_if.sv
// Data and status bundle between a FIFO user (master) and the FIFO (slave).
`timescale 1ns/1ps
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
);
    // valid_write is accepted on a rising edge unless full (a same-edge accepted read frees a slot);
    // valid_read is accepted on a rising edge unless empty, and data_out updates on that same edge.
    logic [SIZE-1:0] data_in;
    logic            valid_write;
    logic            valid_read;
    logic [SIZE-1:0] data_out;
    logic            full_flag;
    logic            empty_flag;
    logic            almost_full_flag;
    logic            almost_empty_flag;

    modport master (
        output data_in, valid_write, valid_read,
        input  data_out, full_flag, empty_flag, almost_full_flag, almost_empty_flag
    );

    modport slave (
        input  data_in, valid_write, valid_read,
        output data_out, full_flag, empty_flag, almost_full_flag, almost_empty_flag
    );
endinterface

// File: rtl/fifo_mem.sv
// 2**DEPTH x SIZE storage with one write port and a registered read port.
`timescale 1ns/1ps
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [SIZE-1:0]  wdata,
    input  logic             re,
    input  logic [DEPTH-1:0] raddr,
    output logic [SIZE-1:0]  rdata
);
    logic [SIZE-1:0] mem [2**DEPTH];

    // Array is never reset; only the pointers decide which entries are live.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    // A same-edge write to raddr is not seen here: the read returns the old entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  rdata <= '0;
        else if (re)   rdata <= mem[raddr];
    end
endmodule

// File: rtl/fifo.sv
// Synchronous FIFO: pointer, occupancy and flag control around fifo_mem.
`timescale 1ns/1ps
module fifo
    import fifo_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic  clock,
    input logic  reset_n,
    fifo_if.slave bus
);
    localparam logic [DEPTH:0] CAP    = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0] CAP_M1 = CAP - 1'b1;
    localparam logic [DEPTH:0] ONE    = {{DEPTH{1'b0}}, 1'b1};

    logic [DEPTH-1:0] wr_ptr, rd_ptr;
    logic [DEPTH:0]   count, count_next;
    logic             rd_ok, wr_ok;
    logic             full_q, empty_q, afull_q, aempty_q;

    // A write into a full FIFO is allowed only when a read frees the slot on the same edge.
    assign rd_ok = bus.valid_read && (count != '0);
    assign wr_ok = bus.valid_write && ((count != CAP) || rd_ok);

    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Flags are registered from the next count so they move exactly with count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            full_q   <= (count_next == CAP);
            empty_q  <= (count_next == '0);
            afull_q  <= (count_next == CAP_M1);
            aempty_q <= (count_next == ONE);
        end
    end

    fifo_mem #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (wr_ok),
        .waddr   (wr_ptr),
        .wdata   (bus.data_in),
        .re      (rd_ok),
        .raddr   (rd_ptr),
        .rdata   (bus.data_out)
    );

    assign bus.full_flag         = full_q;
    assign bus.empty_flag        = empty_q;
    assign bus.almost_full_flag  = afull_q;
    assign bus.almost_empty_flag = aempty_q;
endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for fifo: queue-based reference model, per-cycle expectations, monitor compares.
`timescale 1ns/1ps
module tb_fifo;
  localparam int W   = 8;
  localparam int CAP = 4;
  localparam int EW  = W + 4;

  logic clock;
  logic reset_n;

  fifo_if #(.SIZE(W)) bus ();

  fifo #(.SIZE(W), .DEPTH(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model: stored entries in arrival order plus the last value read out
  logic [W-1:0]  model_q[$];
  logic [W-1:0]  model_dout;
  logic [EW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] flags_for(input int n);
    return {n == CAP, n == 0, n == CAP - 1, n == 1};
  endfunction

  function automatic logic [3:0] dut_flags();
    return {bus.full_flag, bus.empty_flag, bus.almost_full_flag, bus.almost_empty_flag};
  endfunction

  // driver: one clock cycle of stimulus, expectation pushed for the monitor
  task automatic cycle(input bit vw, input bit vr, input int d);
    bit rd_ok, wr_ok;
    int n;
    @(negedge clock);
    bus.valid_write = vw;
    bus.valid_read  = vr;
    bus.data_in     = d[W-1:0];
    rd_ok = vr && (model_q.size() != 0);
    wr_ok = vw && (model_q.size() < CAP || rd_ok);
    if (rd_ok) model_dout = model_q.pop_front();
    if (wr_ok) model_q.push_back(d[W-1:0]);
    n = model_q.size();
    exp_q.push_back({model_dout, flags_for(n)});
  endtask

  task automatic idle_inputs();
    bus.valid_write = 1'b0;
    bus.valid_read  = 1'b0;
    bus.data_in     = '0;
  endtask

  // asynchronous reset pulse of 60 ps placed away from any clock edge
  task automatic reset_pulse(input string name);
    @(posedge clock);
    #2;
    idle_inputs();
    reset_n = 1'b0;
    #0.03;
    check({name, "_dout"},  EW'(bus.data_out), EW'(0));
    check({name, "_flags"}, EW'(dut_flags()),  EW'(4'b0100));
    #0.03;
    reset_n = 1'b1;
    model_q.delete();
    model_dout = '0;
  endtask

  // monitor: compares DUT outputs after every edge that has an expectation
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dout",  EW'(bus.data_out), EW'(e[EW-1:4]));
        check("flags", EW'(dut_flags()),  EW'(e[3:0]));
      end
    end
  end

  initial begin
    int fill_vals[5];
    int budget;
    fill_vals = '{21, 503, 90, 10, 20};
    reset_n = 1'b1;
    idle_inputs();
    model_dout = '0;
    #2;
    reset_n = 1'b0;
    #0.03;
    check("rst_dout",  EW'(bus.data_out), EW'(0));
    check("rst_flags", EW'(dut_flags()),  EW'(4'b0100));
    #0.03;
    reset_n = 1'b1;

    // fill past capacity, then drain past empty
    foreach (fill_vals[i]) cycle(1'b1, 1'b0, fill_vals[i]);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 0);

    // streaming through pointer wrap
    cycle(1'b1, 1'b0, 0);
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, i);
    cycle(1'b0, 1'b1, 0);

    // simultaneous read and write while full
    for (int i = 10; i <= 13; i++) cycle(1'b1, 1'b0, i);
    cycle(1'b1, 1'b1, 14);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 0);

    // reset with data stored, then a read that must be ignored
    for (int i = 30; i < 33; i++) cycle(1'b1, 1'b0, i);
    reset_pulse("midrst");
    cycle(1'b0, 1'b1, 0);
    cycle(1'b0, 1'b0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    cycle(1'b0, 1'b0, 0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clock);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
